// File: rtl/ddr_write_fifo_pkg.sv
// Shared defaults for the 32-to-256 bit DDR write FIFO.
// Holds width/depth defaults, the packing ratio and its log2.
package ddr_write_fifo_pkg;

    localparam int DEF_WR_DEPTH_WIDTH   = 13;
    localparam int DEF_WR_DATA_WIDTH    = 32;
    localparam int DEF_RD_DEPTH_WIDTH   = 10;
    localparam int DEF_RD_DATA_WIDTH    = 256;
    localparam int DEF_ALMOST_FULL_NUM  = 1020;
    localparam int DEF_ALMOST_EMPTY_NUM = 4;

    localparam int RATIO     = DEF_RD_DATA_WIDTH / DEF_WR_DATA_WIDTH;
    localparam int LANE_BITS = $clog2(RATIO);

endpackage

// File: rtl/ddr_write_fifo_if.sv
// Write/read bundle of the DDR write FIFO.
// master: capture writer + burst reader; slave: the FIFO.
interface ddr_write_fifo_if
    import ddr_write_fifo_pkg::*;
#(
    parameter int WR_DEPTH_WIDTH = DEF_WR_DEPTH_WIDTH,
    parameter int WR_DATA_WIDTH  = DEF_WR_DATA_WIDTH,
    parameter int RD_DEPTH_WIDTH = DEF_RD_DEPTH_WIDTH,
    parameter int RD_DATA_WIDTH  = DEF_RD_DATA_WIDTH
);

    logic [WR_DATA_WIDTH-1:0]  wr_data;
    logic                      wr_en;
    logic                      wr_full;
    logic [WR_DEPTH_WIDTH:0]   wr_water_level;
    logic                      almost_full;
    logic [RD_DATA_WIDTH-1:0]  rd_data;
    logic                      rd_en;
    logic                      rd_empty;
    logic [RD_DEPTH_WIDTH:0]   rd_water_level;
    logic                      almost_empty;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, wr_water_level, almost_full,
        input  rd_data, rd_empty, rd_water_level, almost_empty
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, wr_water_level, almost_full,
        output rd_data, rd_empty, rd_water_level, almost_empty
    );

endinterface

// File: rtl/ddr_fifo_ram.sv
// Simple dual-port RAM with per-lane write enables.
// Ports: we/waddr/wdata write lanes; re/raddr read into rdata (registered).
module ddr_fifo_ram #(
    parameter int ADDR_W = 10,
    parameter int LANE_W = 32,
    parameter int LANES  = 8
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES-1:0]          we,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [LANES*LANE_W-1:0]   wdata,
    input  logic                      re,
    input  logic [ADDR_W-1:0]         raddr,
    output logic [LANES*LANE_W-1:0]   rdata
);

    localparam int DATA_W = LANES * LANE_W;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // Output register holds its value unless a read is accepted.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ddr_write_fifo.sv
// Width-converting FIFO packing 32-bit words LSB-first into 256-bit rows.
// Ports: clk, rst_n (async, active-low), bus (slave side of ddr_write_fifo_if).
module ddr_write_fifo
    import ddr_write_fifo_pkg::*;
#(
    parameter int WR_DEPTH_WIDTH   = DEF_WR_DEPTH_WIDTH,
    parameter int WR_DATA_WIDTH    = DEF_WR_DATA_WIDTH,
    parameter int RD_DEPTH_WIDTH   = DEF_RD_DEPTH_WIDTH,
    parameter int RD_DATA_WIDTH    = DEF_RD_DATA_WIDTH,
    parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
    parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
)(
    input  logic              clk,
    input  logic              rst_n,
    ddr_write_fifo_if.slave   bus
);

    localparam int LANES = RD_DATA_WIDTH / WR_DATA_WIDTH;
    localparam int LBITS = $clog2(LANES);

    typedef logic [WR_DEPTH_WIDTH:0] wcnt_t;
    typedef logic [RD_DEPTH_WIDTH:0] rcnt_t;

    localparam wcnt_t FULL_CNT = wcnt_t'(2**WR_DEPTH_WIDTH);
    localparam wcnt_t AF_CNT   = wcnt_t'(ALMOST_FULL_NUM);
    localparam rcnt_t AE_CNT   = rcnt_t'(ALMOST_EMPTY_NUM);

    wcnt_t wp_q, wp_d;
    wcnt_t count_q, count_d;
    rcnt_t rp_q, rp_d;
    rcnt_t rd_level;
    logic  full;
    logic  empty;
    logic  wr_acc;
    logic  rd_acc;
    logic [LANES-1:0] lane_we;

    assign full     = (count_q == FULL_CNT);
    assign rd_level = rcnt_t'(count_q >> LBITS);
    assign empty    = (rd_level == '0);
    assign wr_acc   = bus.wr_en && !full;
    assign rd_acc   = bus.rd_en && !empty;

    // Count is re-derived from the next pointers so a simultaneous
    // read and write nets out to +1 - LANES without a separate path.
    always_comb begin
        wp_d    = wp_q + wcnt_t'(wr_acc);
        rp_d    = rp_q + rcnt_t'(rd_acc);
        count_d = wp_d - wcnt_t'({rp_d, {LBITS{1'b0}}});
        lane_we = '0;
        if (wr_acc) begin
            lane_we[wp_q[LBITS-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    ddr_fifo_ram #(
        .ADDR_W (RD_DEPTH_WIDTH),
        .LANE_W (WR_DATA_WIDTH),
        .LANES  (LANES)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (lane_we),
        .waddr  (wp_q[WR_DEPTH_WIDTH-1:LBITS]),
        .wdata  ({LANES{bus.wr_data}}),
        .re     (rd_acc),
        .raddr  (rp_q[RD_DEPTH_WIDTH-1:0]),
        .rdata  (bus.rd_data)
    );

    assign bus.wr_full        = full;
    assign bus.wr_water_level = count_q;
    assign bus.almost_full    = (count_q >= AF_CNT);
    assign bus.rd_empty       = empty;
    assign bus.rd_water_level = rd_level;
    assign bus.almost_empty   = (rd_level <= AE_CNT);

endmodule

// File: tb/tb_ddr_write_fifo.sv
// Directed self-checking bench for ddr_write_fifo.
// Fill/drain, full/empty edges, concurrent access, async reset.
module tb_ddr_write_fifo;
    import ddr_write_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ddr_write_fifo_if bus ();

    ddr_write_fifo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_row(input logic [31:0] first,
                                            input bit dec);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            r[32*j +: 32] = dec ? first - 32'(j) : first + 32'(j);
        end
        return r;
    endfunction

    task automatic push(input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
    endtask

    task automatic both(input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check("rst_empty", bus.rd_empty, 1);
        check("rst_ae", bus.almost_empty, 1);
        check("rst_full", bus.wr_full, 0);
        check("rst_af", bus.almost_full, 0);
        check("rst_wrl", bus.wr_water_level, 0);
        check("rst_rdl", bus.rd_water_level, 0);
        check("rst_rdata", bus.rd_data, 0);

        for (int i = 0; i < 8192; i++) begin
            push(32'hFFFF_FFFF - 32'(i));
            if (i == 6) begin
                check("w7_wrl", bus.wr_water_level, 7);
                check("w7_empty", bus.rd_empty, 1);
            end
            if (i == 7) begin
                check("w8_rdl", bus.rd_water_level, 1);
                check("w8_empty", bus.rd_empty, 0);
                check("w8_ae", bus.almost_empty, 1);
            end
            if (i == 1018) check("w1019_af", bus.almost_full, 0);
            if (i == 1019) check("w1020_af", bus.almost_full, 1);
            if (i == 8190) check("w8191_full", bus.wr_full, 0);
        end
        check("fill_full", bus.wr_full, 1);
        check("fill_wrl", bus.wr_water_level, 8192);
        check("fill_rdl", bus.rd_water_level, 1024);
        check("fill_af", bus.almost_full, 1);
        check("fill_ae", bus.almost_empty, 0);

        push(32'hDEAD_BEEF);
        check("ovf_wrl", bus.wr_water_level, 8192);
        check("ovf_full", bus.wr_full, 1);
        check("pre_read", bus.rd_data, 0);

        for (int r = 0; r < 1024; r++) begin
            pop();
            check($sformatf("row%0d", r), bus.rd_data,
                  mk_row(32'hFFFF_FFFF - 32'(8*r), 1'b1));
            if (r == 0) check("r1_rdl", bus.rd_water_level, 1023);
            if (r == 1018) check("r5_ae", bus.almost_empty, 0);
            if (r == 1019) check("r4_ae", bus.almost_empty, 1);
        end
        check("drain_empty", bus.rd_empty, 1);
        check("drain_wrl", bus.wr_water_level, 0);
        pop();
        check("rd_hold", bus.rd_data, mk_row(32'hFFFF_E007, 1'b1));
        check("udf_wrl", bus.wr_water_level, 0);

        for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
        check("s16_wrl", bus.wr_water_level, 16);
        both(32'h110);
        check("rw_wrl", bus.wr_water_level, 9);
        check("rw_rdl", bus.rd_water_level, 1);
        check("rw_row0", bus.rd_data, mk_row(32'h100, 1'b0));
        for (int i = 1; i < 8; i++) push(32'h110 + 32'(i));
        check("rw_wrl16", bus.wr_water_level, 16);
        pop();
        check("rw_row1", bus.rd_data, mk_row(32'h108, 1'b0));
        pop();
        check("rw_row2", bus.rd_data, mk_row(32'h110, 1'b0));
        check("rw_end_wrl", bus.wr_water_level, 0);

        for (int i = 0; i < 4096; i++) push(32'(i));
        pop();
        check("half_wrl", bus.wr_water_level, 4088);
        check("half_row", bus.rd_data, mk_row(32'h0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_wrl", bus.wr_water_level, 0);
        check("ar_rdl", bus.rd_water_level, 0);
        check("ar_empty", bus.rd_empty, 1);
        check("ar_full", bus.wr_full, 0);
        check("ar_af", bus.almost_full, 0);
        check("ar_ae", bus.almost_empty, 1);
        check("ar_rdata", bus.rd_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
        check("post_rdl", bus.rd_water_level, 1);
        pop();
        check("post_row0", bus.rd_data, mk_row(32'hA0, 1'b0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
